// File: rtl/jace_vram_arbiter.sv
// Jupiter ACE style video RAM arbiter.
// Video fetch owns the RAM on fixed cell phases; CPU gets WAIT otherwise.
module jace_vram_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       viden,
  input  logic [2:0] phase,
  input  logic [9:0] vid_scr_addr,
  input  logic [9:0] vid_chr_addr,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic       cpu_sel,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,
  output logic       wait_n,
  output logic       ram_cs_scr,
  output logic       ram_cs_chr,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata_scr,
  input  logic [7:0] ram_rdata_chr,
  output logic [7:0] vid_scr_data,
  output logic [7:0] vid_chr_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPT,
    S_DONE
  } state_t;

  state_t     state_q;
  logic       sel_q;
  logic       we_q;
  logic [7:0] rdata_q;
  logic       ack_q;
  logic [7:0] vscr_q;
  logic [7:0] vchr_q;

  logic slot_ok;
  logic vid_scr_go;
  logic vid_chr_go;
  logic cpu_go;

  assign slot_ok    = !viden ||
                      (phase >= 3'd4 && phase <= 3'd6);
  assign vid_scr_go = viden && (phase == 3'd0);
  assign vid_chr_go = viden && (phase == 3'd2);
  assign cpu_go     = !rst && (state_q == S_IDLE) &&
                      cpu_req && slot_ok;

  // Shared RAM port mux: video slots first, then a granted CPU issue.
  always_comb begin
    ram_cs_scr = 1'b0;
    ram_cs_chr = 1'b0;
    ram_addr   = 10'd0;
    ram_we     = 1'b0;
    ram_wdata  = 8'd0;
    if (rst) begin
      ram_cs_scr = 1'b0;
    end else if (vid_scr_go) begin
      ram_cs_scr = 1'b1;
      ram_addr   = vid_scr_addr;
    end else if (vid_chr_go) begin
      ram_cs_chr = 1'b1;
      ram_addr   = vid_chr_addr;
    end else if (cpu_go) begin
      ram_cs_scr = !cpu_sel;
      ram_cs_chr = cpu_sel;
      ram_addr   = cpu_addr;
      ram_we     = cpu_we;
      ram_wdata  = cpu_wdata;
    end
  end

  // CPU access FSM: issue, capture read data, hold until request drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= 8'd0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cpu_go) begin
            sel_q   <= cpu_sel;
            we_q    <= cpu_we;
            state_q <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (!we_q)
            rdata_q <= sel_q ? ram_rdata_chr
                             : ram_rdata_scr;
          ack_q   <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (!cpu_req)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Video fetch capture one cycle after each video RAM slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      vscr_q <= 8'd0;
      vchr_q <= 8'd0;
    end else if (viden) begin
      if (phase == 3'd1)
        vscr_q <= ram_rdata_scr;
      if (phase == 3'd3)
        vchr_q <= ram_rdata_chr;
    end
  end

  assign wait_n       = rst || !cpu_req ||
                        (state_q == S_DONE);
  assign cpu_rdata    = rdata_q;
  assign cpu_ack      = ack_q;
  assign vid_scr_data = vscr_q;
  assign vid_chr_data = vchr_q;

endmodule

// File: tb/tb_jace_vram_arbiter.sv
// Directed bench for jace_vram_arbiter.
// Includes a synchronous RAM model and a bus monitor.
module tb_jace_vram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       viden;
  logic [2:0] phase;
  logic [9:0] vid_scr_addr;
  logic [9:0] vid_chr_addr;
  logic       cpu_req;
  logic       cpu_we;
  logic       cpu_sel;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;
  logic       wait_n;
  logic       ram_cs_scr;
  logic       ram_cs_chr;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata_scr;
  logic [7:0] ram_rdata_chr;
  logic [7:0] vid_scr_data;
  logic [7:0] vid_chr_data;

  logic [7:0] scr_mem [1024];
  logic [7:0] chr_mem [1024];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int ack_cnt = 0;
  int viol_cnt = 0;
  int we0;
  int ack0;

  always #5 clk = ~clk;

  jace_vram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .viden        (viden),
    .phase        (phase),
    .vid_scr_addr (vid_scr_addr),
    .vid_chr_addr (vid_chr_addr),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_sel      (cpu_sel),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .wait_n       (wait_n),
    .ram_cs_scr   (ram_cs_scr),
    .ram_cs_chr   (ram_cs_chr),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata_scr(ram_rdata_scr),
    .ram_rdata_chr(ram_rdata_chr),
    .vid_scr_data (vid_scr_data),
    .vid_chr_data (vid_chr_data)
  );

  always @(posedge clk) begin
    if (ram_cs_scr) begin
      if (ram_we) scr_mem[ram_addr] <= ram_wdata;
      ram_rdata_scr <= scr_mem[ram_addr];
    end
    if (ram_cs_chr) begin
      if (ram_we) chr_mem[ram_addr] <= ram_wdata;
      ram_rdata_chr <= chr_mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (cpu_ack) ack_cnt++;
    if (ram_cs_scr && ram_cs_chr) viol_cnt++;
    if (viden && (ram_cs_scr || ram_cs_chr) &&
        (phase == 3'd1 || phase == 3'd3 ||
         phase == 3'd7))
      viol_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    phase = phase + 3'd1;
  endtask

  task automatic to_phase(input logic [2:0] p);
    for (int i = 0; i < 8 && phase != p; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      scr_mem[i] = 8'h00;
      chr_mem[i] = 8'h00;
    end
    scr_mem[10'h155] = 8'hA5;
    scr_mem[10'h020] = 8'h81;
    scr_mem[10'h1F0] = 8'h5A;
    chr_mem[10'h008] = 8'hFF;
    ram_rdata_scr = 8'h00;
    ram_rdata_chr = 8'h00;

    rst = 1'b1; viden = 1'b1; phase = 3'd0;
    vid_scr_addr = 10'h020; vid_chr_addr = 10'h008;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_sel = 1'b0;
    cpu_addr = 10'h155; cpu_wdata = 8'h11;

    // reset holds everything quiet, even at a video slot
    tick(); tick();
    to_phase(3'd0);
    #2;
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_ack", cpu_ack, 1'b0);
    chk("rst_wait", wait_n, 1'b1);
    chk("rst_vscr", vid_scr_data, 8'h00);
    chk("rst_vchr", vid_chr_data, 8'h00);
    chk("rst_cs", {ram_cs_scr, ram_cs_chr}, 2'b00);
    chk("rst_addr", ram_addr, 10'h000);
    chk("rst_we", ram_we, 1'b0);
    cpu_req = 1'b0; viden = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // viden=0 read of screen 0x155
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_sel = 1'b0;
    cpu_addr = 10'h155;
    #2;
    chk("r1_cs", {ram_cs_scr, ram_cs_chr}, 2'b10);
    chk("r1_addr", ram_addr, 10'h155);
    chk("r1_we", ram_we, 1'b0);
    chk("r1_wait0", wait_n, 1'b0);
    tick(); #2;
    chk("r1_capt_cs", {ram_cs_scr, ram_cs_chr}, 2'b00);
    chk("r1_wait1", wait_n, 1'b0);
    chk("r1_ack_early", cpu_ack, 1'b0);
    tick(); #2;
    chk("r1_ack", cpu_ack, 1'b1);
    chk("r1_rdata", cpu_rdata, 8'hA5);
    chk("r1_wait2", wait_n, 1'b1);
    cpu_req = 1'b0;
    tick(); #2;
    chk("r1_ack_pulse", cpu_ack, 1'b0);

    // viden=1 write of char 0x010 requested at phase 0
    to_phase(3'd0);
    we0 = we_cnt;
    ack0 = ack_cnt;
    viden = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_sel = 1'b1;
    cpu_addr = 10'h010; cpu_wdata = 8'h3C;
    #2;
    chk("w2_p0_cs", {ram_cs_scr, ram_cs_chr}, 2'b10);
    chk("w2_p0_addr", ram_addr, 10'h020);
    chk("w2_p0_we", ram_we, 1'b0);
    chk("w2_p0_wait", wait_n, 1'b0);
    tick(); #2;
    chk("w2_p1_cs", {ram_cs_scr, ram_cs_chr}, 2'b00);
    tick(); #2;
    chk("w2_p2_cs", {ram_cs_scr, ram_cs_chr}, 2'b01);
    chk("w2_p2_addr", ram_addr, 10'h008);
    chk("w2_p2_we", ram_we, 1'b0);
    chk("w2_p2_vscr", vid_scr_data, 8'h81);
    tick(); #2;
    chk("w2_p3_cs", {ram_cs_scr, ram_cs_chr}, 2'b00);
    chk("w2_p3_wait", wait_n, 1'b0);
    tick(); #2;
    chk("w2_p4_cs", {ram_cs_scr, ram_cs_chr}, 2'b01);
    chk("w2_p4_addr", ram_addr, 10'h010);
    chk("w2_p4_we", ram_we, 1'b1);
    chk("w2_p4_wdata", ram_wdata, 8'h3C);
    chk("w2_p4_vchr", vid_chr_data, 8'hFF);
    tick(); #2;
    chk("w2_p5_we", ram_we, 1'b0);
    chk("w2_p5_wait", wait_n, 1'b0);
    tick(); #2;
    chk("w2_p6_ack", cpu_ack, 1'b1);
    chk("w2_p6_wait", wait_n, 1'b1);
    chk("w2_p6_rdata", cpu_rdata, 8'hA5);
    for (int i = 0; i < 10; i++) tick();
    #2;
    chk("w2_we_pulses", 16'(we_cnt - we0), 16'd1);
    chk("w2_acks", 16'(ack_cnt - ack0), 16'd1);
    chk("w2_mem", chr_mem[10'h010], 8'h3C);
    cpu_req = 1'b0;
    tick();

    // viden=1 read requested at phase 7
    to_phase(3'd7);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_sel = 1'b0;
    cpu_addr = 10'h1F0;
    #2;
    chk("r3_p7_cs", {ram_cs_scr, ram_cs_chr}, 2'b00);
    chk("r3_p7_wait", wait_n, 1'b0);
    tick(); #2;
    chk("r3_p0_addr", ram_addr, 10'h020);
    chk("r3_p0_we", ram_we, 1'b0);
    tick(); #2;
    chk("r3_p1_cs", {ram_cs_scr, ram_cs_chr}, 2'b00);
    tick(); #2;
    chk("r3_p2_addr", ram_addr, 10'h008);
    tick(); #2;
    chk("r3_p3_cs", {ram_cs_scr, ram_cs_chr}, 2'b00);
    tick(); #2;
    chk("r3_p4_cs", {ram_cs_scr, ram_cs_chr}, 2'b10);
    chk("r3_p4_addr", ram_addr, 10'h1F0);
    tick(); tick(); #2;
    chk("r3_p6_ack", cpu_ack, 1'b1);
    chk("r3_p6_rdata", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;
    tick();

    // viden=0 holds the video fetch results
    to_phase(3'd0);
    viden = 1'b0;
    vid_scr_addr = 10'h155; vid_chr_addr = 10'h010;
    #2;
    chk("v4_p0_cs", {ram_cs_scr, ram_cs_chr}, 2'b00);
    for (int i = 0; i < 8; i++) tick();
    #2;
    chk("v4_vscr", vid_scr_data, 8'h81);
    chk("v4_vchr", vid_chr_data, 8'hFF);

    // reset during CAPT of a write aborts the access
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_sel = 1'b0;
    cpu_addr = 10'h300; cpu_wdata = 8'h77;
    #2;
    chk("x5_issue_we", ram_we, 1'b1);
    tick();
    ack0 = ack_cnt;
    rst = 1'b1;
    #2;
    chk("x5_rst_wait", wait_n, 1'b1);
    chk("x5_rst_cs", {ram_cs_scr, ram_cs_chr, ram_we}, 3'b000);
    tick(); #2;
    chk("x5_rst_ack", cpu_ack, 1'b0);
    chk("x5_rst_rdata", cpu_rdata, 8'h00);
    chk("x5_ack_cnt", 16'(ack_cnt - ack0), 16'd0);
    rst = 1'b0;
    #2;
    chk("x5_rearb_cs", {ram_cs_scr, ram_we}, 2'b11);
    chk("x5_rearb_wait", wait_n, 1'b0);
    tick(); tick(); #2;
    chk("x5_rearb_ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick(); tick(); #2;
    chk("x5_read_ack", cpu_ack, 1'b1);
    chk("x5_read_data", cpu_rdata, 8'h77);
    cpu_req = 1'b0;
    tick(); tick();

    chk("bus_conflicts", 16'(viol_cnt), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
